// File: rtl/mul_share_if.sv
// mul_share_if: requester, shared-multiplier and result signals of mul_share_ctrl
interface mul_share_if #(parameter int W = 128);
  logic           req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic [W-1:0]   mul_a, mul_b;
  logic [2*W-1:0] mul_p, res_p;
  logic           res_valid, res_id, res_ready, busy;
  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, mul_p, res_ready,
    input  req0_ready, req1_ready, mul_a, mul_b, res_valid, res_p, res_id, busy
  );
  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, mul_p, res_ready,
    output req0_ready, req1_ready, mul_a, mul_b, res_valid, res_p, res_id, busy
  );
endinterface

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin sharing of one external multiplier between two requesters
module mul_share_ctrl #(
  parameter int W       = 128,
  parameter int MUL_CYC = 2
) (
  input logic      clk,
  input logic      rst_n,
  mul_share_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(MUL_CYC - 1);
  logic [1:0]     state_q;
  logic           prio_q, id_q, res_id_q, res_valid_q;
  logic [3:0]     cnt_q;
  logic [W-1:0]   mul_a_q, mul_b_q;
  logic [2*W-1:0] res_p_q;
  logic           any_d, gnt_d, idle_d;
  // arbitration: a lone requester wins, otherwise the round-robin pointer decides
  always_comb begin
    any_d  = bus.req0_valid | bus.req1_valid;
    gnt_d  = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;
    idle_d = state_q == IDLE;
  end
  assign bus.req0_ready = rst_n && idle_d && any_d && !gnt_d;
  assign bus.req1_ready = rst_n && idle_d && any_d && gnt_d;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.res_p      = res_p_q;
  assign bus.res_id     = res_id_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.busy       = !idle_d;
  // IDLE grants and latches operands, WAIT lets the multiplier settle, DONE holds the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      res_p_q     <= '0;
      res_id_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (any_d) begin
          mul_a_q <= gnt_d ? bus.req1_a : bus.req0_a;
          mul_b_q <= gnt_d ? bus.req1_b : bus.req0_b;
          id_q    <= gnt_d;
          prio_q  <= !gnt_d;
          cnt_q   <= CNT_INIT;
          state_q <= WAIT;
        end
        WAIT: if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end else begin
          res_p_q     <= bus.mul_p;
          res_id_q    <= id_q;
          res_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: if (bus.res_ready) begin
          res_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl: timeline model of grants and result timing plus directed literal checks
module tb_mul_share_ctrl;
  localparam int W = 128, MC = 2, P = 2 * W;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  mul_share_if #(.W(W)) bus ();
  mul_share_ctrl #(.W(W), .MUL_CYC(MC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  assign bus.mul_p = P'(bus.mul_a) * P'(bus.mul_b);
  int checks = 0, failures = 0, cyc = 0, due = 0;
  logic busy_m, rv_m, prio_m, id_m, last_id;
  logic [W-1:0] ea, eb;
  logic [P-1:0] exp_p, last_p, all1;
  int log_id[$];
  int log_cyc[$];
  logic [P-1:0] log_p[$];
  task automatic chk(input string nm, input logic [P-1:0] act, input logic [P-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask
  task automatic mreset;
    busy_m = 0; rv_m = 0; prio_m = 0; id_m = 0; last_id = 0;
    ea = '0; eb = '0; exp_p = '0; last_p = '0; due = 0;
  endtask
  task automatic tick;
    logic g;
    @(posedge clk);
    cyc++;
    if (!busy_m) begin
      if (bus.req0_valid || bus.req1_valid) begin
        g = (bus.req0_valid && bus.req1_valid) ? prio_m : bus.req1_valid;
        prio_m = !g; id_m = g;
        ea = g ? bus.req1_a : bus.req0_a;
        eb = g ? bus.req1_b : bus.req0_b;
        exp_p = P'(ea) * P'(eb);
        due = cyc + MC;
        busy_m = 1;
      end
    end else if (rv_m) begin
      if (bus.res_ready) begin
        log_id.push_back(int'(last_id)); log_p.push_back(last_p); log_cyc.push_back(cyc);
        rv_m = 0; busy_m = 0;
      end
    end else if (cyc == due) begin
      rv_m = 1; last_p = exp_p; last_id = id_m;
    end
    @(negedge clk);
    g = (bus.req0_valid && bus.req1_valid) ? prio_m : bus.req1_valid;
    chk("ready0", bus.req0_ready, !busy_m && (bus.req0_valid || bus.req1_valid) && !g);
    chk("ready1", bus.req1_ready, !busy_m && (bus.req0_valid || bus.req1_valid) && g);
    chk("busy", bus.busy, busy_m);
    chk("res_valid", bus.res_valid, rv_m);
    chk("res_p", bus.res_p, last_p);
    chk("res_id", bus.res_id, last_id);
    chk("mul_a", bus.mul_a, ea);
    chk("mul_b", bus.mul_b, eb);
  endtask
  task automatic do_reset;
    rst_n = 0;
    #1;
    mreset();
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_p", bus.res_p, 0);
    chk("rst_id", bus.res_id, 0);
    chk("rst_mul_a", bus.mul_a, 0);
    chk("rst_mul_b", bus.mul_b, 0);
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    log_id.delete(); log_p.delete(); log_cyc.delete();
  endtask
  task automatic run_until(input int n, input int mx);
    for (int k = 0; k < mx && log_id.size() < n; k++) tick();
    chk("timeout", log_id.size() >= n, 1);
  endtask
  task automatic drain;
    for (int k = 0; k < 20 && busy_m; k++) tick();
    chk("drain", busy_m, 0);
  endtask
  task automatic idle_inputs;
    bus.req0_valid = 0; bus.req1_valid = 0;
  endtask
  initial begin
    bus.req0_valid = 0; bus.req1_valid = 0; bus.res_ready = 0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
    mreset();
    do_reset();
    bus.req0_valid = 1; bus.req0_a = 57; bus.req0_b = 9495;
    tick();
    idle_inputs();
    chk("t1_rv_t0", bus.res_valid, 0);
    tick();
    chk("t1_rv_t1", bus.res_valid, 0);
    tick();
    chk("t1_rv_t2", bus.res_valid, 1);
    chk("t1_p", bus.res_p, 541215);
    chk("t1_id", bus.res_id, 0);
    bus.res_ready = 1;
    tick();
    chk("t1_rv_fall", bus.res_valid, 0);
    chk("t1_p_keep", bus.res_p, 541215);
    do_reset();
    bus.req0_valid = 1; bus.req0_a = 5711; bus.req0_b = 50000000;
    bus.req1_valid = 1; bus.req1_a = 122457; bus.req1_b = 9495;
    run_until(2, 30);
    idle_inputs();
    drain();
    if (log_id.size() >= 2) begin
      chk("t2_id0", log_id[0], 0);
      chk("t2_p0", log_p[0], 64'd285550000000);
      chk("t2_id1", log_id[1], 1);
      chk("t2_p1", log_p[1], 64'd1162729215);
    end
    do_reset();
    bus.req0_valid = 1; bus.req0_a = 57568; bus.req0_b = 459394;
    bus.req1_valid = 1; bus.req1_a = 3; bus.req1_b = 7;
    run_until(4, 60);
    idle_inputs();
    drain();
    if (log_id.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("t3_id%0d", i), log_id[i], i % 2);
      chk("t3_p0", log_p[0], 64'd26446393792);
      chk("t3_p2", log_p[2], 64'd26446393792);
      chk("t3_p1", log_p[1], 21);
      chk("t3_period", log_cyc[1] - log_cyc[0], MC + 2);
    end
    do_reset();
    bus.res_ready = 0;
    bus.req0_valid = 1; bus.req0_a = 1234; bus.req0_b = 5678;
    tick();
    for (int k = 0; k < 10 && !bus.res_valid; k++) tick();
    bus.req1_valid = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_rv", bus.res_valid, 1);
      chk("t4_p", bus.res_p, 7006652);
      chk("t4_id", bus.res_id, 0);
      chk("t4_r0", bus.req0_ready, 0);
      chk("t4_r1", bus.req1_ready, 0);
      chk("t4_busy", bus.busy, 1);
    end
    idle_inputs();
    bus.res_ready = 1;
    drain();
    do_reset();
    all1 = '0;
    all1 = all1 - (P'(1) << (W + 1)) + P'(1);
    bus.req1_valid = 1; bus.req1_a = '1; bus.req1_b = '1;
    run_until(1, 20);
    idle_inputs();
    drain();
    if (log_p.size() >= 1) chk("t5_full", log_p[0], all1);
    bus.req0_valid = 1; bus.req0_a = 77; bus.req0_b = 99;
    tick();
    idle_inputs();
    tick();
    bus.req0_valid = 1; bus.req0_a = 11; bus.req0_b = 13;
    bus.req1_valid = 1; bus.req1_a = 17; bus.req1_b = 19;
    do_reset();
    run_until(1, 20);
    idle_inputs();
    drain();
    if (log_id.size() >= 1) begin
      chk("t6_id", log_id[0], 0);
      chk("t6_p", log_p[0], 143);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
